load_store_unit: RTL and testbench

- Initiator side of the core's data-memory port: takes one load/store request at a time from the execute stage and drives the 32-bit, byte-addressed, little-endian data memory.
- The memory reads combinationally: 4 bytes starting at the address, valid only while mem_read is high. It writes 4 bytes at the posedge while mem_write is high.
- Adds RV32I size handling: LB/LH/LW/LBU/LHU and SB/SH/SW. Sub-word stores use read-modify-write. Out-of-range or illegal requests are reported as faults.

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/lsu_byte_lane.sv | 44 ++++
 rtl/load_store_unit.sv | 134 +++++++++++++
 tb/tb_load_store_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - RV32I load/store funct3 encodings
//   - FSM state encoding (3-bit) and the state enum built on it
//   - Fault cause enum, kept for a future cause output
//   - Legality helper for funct3 by access direction
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_RMW_RD = 3'd2;
  localparam logic [2:0] ST_WRITE  = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LOAD   = ST_LOAD,
    RMW_RD = ST_RMW_RD,
    WRITE  = ST_WRITE,
    RESP   = ST_RESP
  } lsu_state_t;

  typedef enum logic [1:0] {
    FAULT_NONE,
    FAULT_RANGE,
    FAULT_MISALIGN,
    FAULT_ILLEGAL
  } lsu_fault_t;

  // Stores only have byte/half/word; loads additionally have the unsigned forms.
  function automatic logic f3Legal(input logic isStore, input logic [2:0] f3);
    if (isStore) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane logic for the load/store unit.
//   funct3     : access size/signedness of the captured request
//   rdata      : word read from memory, byte 0 = byte at the request address
//   wdata      : store data (low bytes used for SB/SH)
//   loadData   : extracted and sign/zero-extended load result
//   mergedData : read word with the low byte/halfword replaced by store data
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] loadData,
  output logic [31:0] mergedData
);

  logic signed [7:0]  rdByte;
  logic signed [15:0] rdHalf;

  assign rdByte = signed'(rdata[7:0]);
  assign rdHalf = signed'(rdata[15:0]);

  always_comb begin
    loadData = rdata;
    case (funct3)
      F3_B:    loadData = 32'(rdByte);
      F3_BU:   loadData = {24'h0, rdata[7:0]};
      F3_H:    loadData = 32'(rdHalf);
      F3_HU:   loadData = {16'h0, rdata[15:0]};
      default: loadData = rdata;
    endcase
  end

  // Only funct3[1:0] matters for stores; the upper bytes keep the read value.
  always_comb begin
    mergedData = wdata;
    case (funct3[1:0])
      2'b00:   mergedData = {rdata[31:8], wdata[7:0]};
      2'b01:   mergedData = {rdata[31:16], wdata[15:0]};
      default: mergedData = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the core's data-memory port.
// Accepts one request at a time, checks it, then performs a load, a
// full-word store, or a read-modify-write for byte/halfword stores.
//   Clk, Rst          : clock (rising edge), asynchronous active-low reset
//   req_*             : request handshake and payload from execute stage
//   rsp_*             : one-cycle completion pulse with load data / fault
//   mem_*             : combinational-read, posedge-write data memory port
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES        = 64,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state;
  logic [31:0] addrQ;
  logic [2:0]  f3Q;
  logic [31:0] wordQ;
  logic        rspValidQ;
  logic [31:0] rspRdataQ;
  logic        rspFaultQ;
  logic [31:0] loadData;
  logic [31:0] mergedData;
  lsu_fault_t  reqCause;

  // The memory always touches 4 bytes, so the range check uses addr+4 for
  // every size; 33 bits keep addresses near 2^32 from wrapping into range.
  function automatic lsu_fault_t checkReq(input logic isStore, input logic [2:0] f3,
                                          input logic [31:0] addr);
    logic [32:0] endAddr;
    endAddr = {1'b0, addr} + 33'd4;
    if (!f3Legal(isStore, f3)) return FAULT_ILLEGAL;
    if (endAddr > 33'(MEM_BYTES)) return FAULT_RANGE;
    if (!ALLOW_MISALIGNED &&
        (((f3[1:0] == 2'b01) && addr[0]) ||
         ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00))))
      return FAULT_MISALIGN;
    return FAULT_NONE;
  endfunction

  assign reqCause = checkReq(req_store, req_funct3, req_addr);

  lsu_byte_lane uLane (
    .funct3     (f3Q),
    .rdata      (mem_rdata),
    .wdata      (wordQ),
    .loadData   (loadData),
    .mergedData (mergedData)
  );

  // wordQ starts as the store data and is overwritten with the merged word
  // in RMW_RD, so it is exactly what WRITE must present on mem_wdata.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      addrQ     <= '0;
      f3Q       <= '0;
      wordQ     <= '0;
      rspValidQ <= 1'b0;
      rspRdataQ <= '0;
      rspFaultQ <= 1'b0;
    end else begin
      rspValidQ <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addrQ <= req_addr;
            f3Q   <= req_funct3;
            wordQ <= req_wdata;
            if (reqCause != FAULT_NONE) begin
              state     <= RESP;
              rspValidQ <= 1'b1;
              rspFaultQ <= 1'b1;
              rspRdataQ <= '0;
            end else if (!req_store) begin
              state <= LOAD;
            end else if (req_funct3 == F3_W) begin
              state <= WRITE;
            end else begin
              state <= RMW_RD;
            end
          end
        end
        LOAD: begin
          rspRdataQ <= loadData;
          rspFaultQ <= 1'b0;
          rspValidQ <= 1'b1;
          state     <= RESP;
        end
        RMW_RD: begin
          wordQ <= mergedData;
          state <= WRITE;
        end
        WRITE: begin
          rspRdataQ <= '0;
          rspFaultQ <= 1'b0;
          rspValidQ <= 1'b1;
          state     <= RESP;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode the state register alone; an asynchronous reset in WRITE
  // therefore removes mem_write before the next edge.
  assign mem_read  = (state == LOAD) || (state == RMW_RD);
  assign mem_write = (state == WRITE);
  assign mem_addr  = addrQ;
  assign mem_wdata = wordQ;
  assign req_ready = (state == IDLE);
  assign rsp_valid = rspValidQ;
  assign rsp_rdata = rspRdataQ;
  assign rsp_fault = rspFaultQ;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  logic        reqValid, reqStore;
  logic [2:0]  reqF3;
  logic [31:0] reqAddr, reqWdata;

  logic        readyA, rspValidA, rspFaultA, memReadA, memWriteA;
  logic [31:0] rspRdataA, memAddrA, memWdataA, memRdataA;
  logic        readyB, rspValidB, rspFaultB, memReadB, memWriteB;
  logic [31:0] rspRdataB, memAddrB, memWdataB, memRdataB;

  logic [7:0] memA [0:63];
  logic [7:0] memB [0:63];
  logic       preload;

  int nChecks = 0;
  int nFails  = 0;

  load_store_unit #(.MEM_BYTES(64), .ALLOW_MISALIGNED(1'b1)) dutA (
    .Clk(Clk), .Rst(Rst), .req_valid(reqValid), .req_ready(readyA),
    .req_store(reqStore), .req_funct3(reqF3), .req_addr(reqAddr),
    .req_wdata(reqWdata), .rsp_valid(rspValidA), .rsp_rdata(rspRdataA),
    .rsp_fault(rspFaultA), .mem_addr(memAddrA), .mem_wdata(memWdataA),
    .mem_read(memReadA), .mem_write(memWriteA), .mem_rdata(memRdataA)
  );

  load_store_unit #(.MEM_BYTES(64), .ALLOW_MISALIGNED(1'b0)) dutB (
    .Clk(Clk), .Rst(Rst), .req_valid(reqValid), .req_ready(readyB),
    .req_store(reqStore), .req_funct3(reqF3), .req_addr(reqAddr),
    .req_wdata(reqWdata), .rsp_valid(rspValidB), .rsp_rdata(rspRdataB),
    .rsp_fault(rspFaultB), .mem_addr(memAddrB), .mem_wdata(memWdataB),
    .mem_read(memReadB), .mem_write(memWriteB), .mem_rdata(memRdataB)
  );

  function automatic logic [7:0] initByte(input int i);
    case (i)
      16: return 8'h80;  17: return 8'hFF;  18: return 8'h34;  19: return 8'h12;
      20: return 8'h56;  21: return 8'h78;
      32: return 8'h44;  33: return 8'h33;  34: return 8'h22;  35: return 8'h11;
      60: return 8'hA1;  61: return 8'hB2;  62: return 8'hC3;  63: return 8'hD4;
      default: return 8'h00;
    endcase
  endfunction

  // Memory models: combinational read only while mem_read is high.
  always_comb begin
    memRdataA = 32'hDEADBEEF;
    if (memReadA && memAddrA <= 32'd60)
      memRdataA = {memA[memAddrA[5:0] + 6'd3], memA[memAddrA[5:0] + 6'd2],
                   memA[memAddrA[5:0] + 6'd1], memA[memAddrA[5:0]]};
  end

  always_comb begin
    memRdataB = 32'hDEADBEEF;
    if (memReadB && memAddrB <= 32'd60)
      memRdataB = {memB[memAddrB[5:0] + 6'd3], memB[memAddrB[5:0] + 6'd2],
                   memB[memAddrB[5:0] + 6'd1], memB[memAddrB[5:0]]};
  end

  always @(posedge Clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) begin
        memA[i] <= initByte(i);
        memB[i] <= initByte(i);
      end
    end else begin
      if (memWriteA && memAddrA <= 32'd60) begin
        memA[memAddrA[5:0]]        <= memWdataA[7:0];
        memA[memAddrA[5:0] + 6'd1] <= memWdataA[15:8];
        memA[memAddrA[5:0] + 6'd2] <= memWdataA[23:16];
        memA[memAddrA[5:0] + 6'd3] <= memWdataA[31:24];
      end
      if (memWriteB && memAddrB <= 32'd60) begin
        memB[memAddrB[5:0]]        <= memWdataB[7:0];
        memB[memAddrB[5:0] + 6'd1] <= memWdataB[15:8];
        memB[memAddrB[5:0] + 6'd2] <= memWdataB[23:16];
        memB[memAddrB[5:0] + 6'd3] <= memWdataB[31:24];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expData;   // load result, or word at 0x20 after a store
    logic        faultA;    // ALLOW_MISALIGNED=1
    logic        faultB;    // ALLOW_MISALIGNED=0
    int          lat;       // non-fault latency
    int          rd;        // non-fault mem_read cycles
    int          wr;        // non-fault mem_write cycles
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic doPreload();
    preload = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    preload = 1'b0;
  endtask

  task automatic applyVec(input int i);
    vec_t v;
    int latA, latB, nValA, nValB, rdA, rdB, wrA, wrB, ovl, rdyBad;
    logic [31:0] wordA, wordB;
    v = vecs[i];
    latA = 0; latB = 0; nValA = 0; nValB = 0; rdA = 0; rdB = 0;
    wrA = 0; wrB = 0; ovl = 0; rdyBad = 0;
    doPreload();
    reqValid = 1'b1; reqStore = v.store; reqF3 = v.f3;
    reqAddr = v.addr; reqWdata = v.wdata;
    @(posedge Clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge Clk);
      reqValid = 1'b0;
      if (memReadA) rdA++;
      if (memWriteA) wrA++;
      if (memReadB) rdB++;
      if (memWriteB) wrB++;
      if ((memReadA && memWriteA) || (memReadB && memWriteB)) ovl++;
      if (rspValidA) begin nValA++; if (latA == 0) latA = c; if (readyA) rdyBad++; end
      if (rspValidB) begin nValB++; if (latB == 0) latB = c; if (readyB) rdyBad++; end
    end
    check($sformatf("v%0d latA", i), 32'(latA), 32'(v.faultA ? 1 : v.lat));
    check($sformatf("v%0d latB", i), 32'(latB), 32'(v.faultB ? 1 : v.lat));
    check($sformatf("v%0d pulsesA", i), 32'(nValA), 32'd1);
    check($sformatf("v%0d pulsesB", i), 32'(nValB), 32'd1);
    check($sformatf("v%0d faultA", i), 32'(rspFaultA), 32'(v.faultA));
    check($sformatf("v%0d faultB", i), 32'(rspFaultB), 32'(v.faultB));
    check($sformatf("v%0d rdataA", i), rspRdataA, (v.store || v.faultA) ? 32'h0 : v.expData);
    check($sformatf("v%0d rdataB", i), rspRdataB, (v.store || v.faultB) ? 32'h0 : v.expData);
    check($sformatf("v%0d readsA", i), 32'(rdA), 32'(v.faultA ? 0 : v.rd));
    check($sformatf("v%0d readsB", i), 32'(rdB), 32'(v.faultB ? 0 : v.rd));
    check($sformatf("v%0d writesA", i), 32'(wrA), 32'(v.faultA ? 0 : v.wr));
    check($sformatf("v%0d writesB", i), 32'(wrB), 32'(v.faultB ? 0 : v.wr));
    check($sformatf("v%0d strobeOverlap", i), 32'(ovl), 32'd0);
    check($sformatf("v%0d readyInResp", i), 32'(rdyBad), 32'd0);
    if (v.store) begin
      wordA = {memA[35], memA[34], memA[33], memA[32]};
      wordB = {memB[35], memB[34], memB[33], memB[32]};
      check($sformatf("v%0d memWordA", i), wordA, v.expData);
      check($sformatf("v%0d memWordB", i), wordB, v.expData);
    end
  endtask

  initial begin
    //            store f3      addr          wdata         expData       fA    fB    lat rd wr
    vecs[0]  = '{1'b0, 3'b010, 32'h10,       32'h0,        32'h1234FF80, 1'b0, 1'b0, 2, 1, 0};
    vecs[1]  = '{1'b0, 3'b000, 32'h10,       32'h0,        32'hFFFFFF80, 1'b0, 1'b0, 2, 1, 0};
    vecs[2]  = '{1'b0, 3'b100, 32'h10,       32'h0,        32'h00000080, 1'b0, 1'b0, 2, 1, 0};
    vecs[3]  = '{1'b0, 3'b001, 32'h10,       32'h0,        32'hFFFFFF80, 1'b0, 1'b0, 2, 1, 0};
    vecs[4]  = '{1'b0, 3'b101, 32'h11,       32'h0,        32'h000034FF, 1'b0, 1'b1, 2, 1, 0};
    vecs[5]  = '{1'b1, 3'b000, 32'h20,       32'hAABBCCDD, 32'h112233DD, 1'b0, 1'b0, 3, 1, 1};
    vecs[6]  = '{1'b1, 3'b001, 32'h20,       32'hAABBCCDD, 32'h1122CCDD, 1'b0, 1'b0, 3, 1, 1};
    vecs[7]  = '{1'b1, 3'b010, 32'h20,       32'hAABBCCDD, 32'hAABBCCDD, 1'b0, 1'b0, 2, 0, 1};
    vecs[8]  = '{1'b0, 3'b010, 32'd60,       32'h0,        32'hD4C3B2A1, 1'b0, 1'b0, 2, 1, 0};
    vecs[9]  = '{1'b0, 3'b010, 32'd61,       32'h0,        32'h0,        1'b1, 1'b1, 1, 0, 0};
    vecs[10] = '{1'b0, 3'b010, 32'hFFFFFFFE, 32'h0,        32'h0,        1'b1, 1'b1, 1, 0, 0};
    vecs[11] = '{1'b0, 3'b011, 32'h10,       32'h0,        32'h0,        1'b1, 1'b1, 1, 0, 0};
    vecs[12] = '{1'b0, 3'b001, 32'h11,       32'h0,        32'h000034FF, 1'b0, 1'b1, 2, 1, 0};
    vecs[13] = '{1'b0, 3'b010, 32'h12,       32'h0,        32'h78561234, 1'b0, 1'b1, 2, 1, 0};
    vecs[14] = '{1'b1, 3'b100, 32'h20,       32'hAABBCCDD, 32'h11223344, 1'b1, 1'b1, 1, 0, 0};
    vecs[15] = '{1'b0, 3'b010, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b1, 1'b1, 1, 0, 0};
    vecs[16] = '{1'b0, 3'b000, 32'h11,       32'h0,        32'hFFFFFFFF, 1'b0, 1'b0, 2, 1, 0};

    Rst = 1'b0; preload = 1'b0; reqValid = 1'b0; reqStore = 1'b0;
    reqF3 = 3'b0; reqAddr = 32'h0; reqWdata = 32'h0;
    repeat (3) @(negedge Clk);

    // Reset state
    check("rst ready", 32'(readyA), 32'd1);
    check("rst rspValid", 32'(rspValidA), 32'd0);
    check("rst rspRdata", rspRdataA, 32'h0);
    check("rst rspFault", 32'(rspFaultA), 32'd0);
    check("rst memRead", 32'(memReadA), 32'd0);
    check("rst memWrite", 32'(memWriteA), 32'd0);
    check("rst memAddr", memAddrA, 32'h0);
    check("rst memWdata", memWdataA, 32'h0);
    check("rst readyB", 32'(readyB), 32'd1);
    Rst = 1'b1;
    @(negedge Clk);

    for (int i = 0; i < NV; i++) applyVec(i);

    // Reset in the WRITE state of an SB read-modify-write
    doPreload();
    reqValid = 1'b1; reqStore = 1'b1; reqF3 = 3'b000;
    reqAddr = 32'h20; reqWdata = 32'hAABBCCDD;
    @(posedge Clk);
    @(negedge Clk);
    reqValid = 1'b0;
    check("abort rmwRead", 32'(memReadA), 32'd1);
    @(negedge Clk);
    check("abort inWrite", 32'(memWriteA), 32'd1);
    check("abort mergedWdata", memWdataA, 32'h112233DD);
    Rst = 1'b0;
    #1;
    check("abort writeDropA", 32'(memWriteA), 32'd0);
    check("abort writeDropB", 32'(memWriteB), 32'd0);
    @(posedge Clk);
    #1;
    check("abort wordA", {memA[35], memA[34], memA[33], memA[32]}, 32'h11223344);
    check("abort wordB", {memB[35], memB[34], memB[33], memB[32]}, 32'h11223344);
    @(negedge Clk);
    Rst = 1'b1;
    #1;
    check("abort readyAfter", 32'(readyA), 32'd1);
    check("abort rspValidAfter", 32'(rspValidA), 32'd0);
    @(negedge Clk);

    // Normal operation resumes after the abort
    applyVec(0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
